// File: rtl/text_rect_sequencer.sv
// Turns a captured four-slot word of 'i'/'u'/'g' codes into a stream of stroke rectangles.
// Optional abort input is enabled by defining TEXT_RECT_SEQUENCER_ABORT_EN.
module text_rect_sequencer #(
  parameter int unsigned PITCH  = 128,
  parameter int unsigned STROKE = 32
) (
  input  logic        clock,
  input  logic        resetn,
`ifdef TEXT_RECT_SEQUENCER_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [31:0] base_x,
  input  logic [31:0] base_y,
  input  logic [7:0]  letters,
  input  logic        rect_ready,
  output logic        rect_valid,
  output logic [31:0] rect_x1,
  output logic [31:0] rect_y1,
  output logic [31:0] rect_x2,
  output logic [31:0] rect_y2,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StEmit, StFinish} state_e;

  localparam logic [1:0]  CodeEnd = 2'd0;
  localparam logic [1:0]  CodeU   = 2'd2;
  localparam logic [1:0]  CodeG   = 2'd3;
  localparam logic [31:0] PitchW  = 32'(PITCH);
  localparam logic [31:0] S1      = 32'(STROKE);
  localparam logic [31:0] S2      = 32'(2 * STROKE);
  localparam logic [31:0] S3      = 32'(3 * STROKE);

  state_e      state_q, state_d;
  logic [31:0] base_x_q, base_x_d;
  logic [31:0] base_y_q, base_y_d;
  logic [7:0]  letters_q, letters_d;
  logic [1:0]  slot_q, slot_d;
  logic [1:0]  stroke_q, stroke_d;

  logic        abort_req;
  logic [1:0]  slot_nxt;
  logic [1:0]  cur_code;
  logic [1:0]  nxt_code;
  logic        last_stroke;
  logic [31:0] ox;
  logic [31:0] dx1, dy1, dx2, dy2;

`ifdef TEXT_RECT_SEQUENCER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign slot_nxt    = slot_q + 2'd1;
  assign cur_code    = letters_q[{slot_q, 1'b0} +: 2];
  assign nxt_code    = letters_q[{slot_nxt, 1'b0} +: 2];
  assign last_stroke = (cur_code == CodeU) ? (stroke_q == 2'd2) : 1'b1;

  always_comb begin
    state_d   = state_q;
    base_x_d  = base_x_q;
    base_y_d  = base_y_q;
    letters_d = letters_q;
    slot_d    = slot_q;
    stroke_d  = stroke_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_x_d  = base_x;
          base_y_d  = base_y;
          letters_d = letters;
          slot_d    = 2'd0;
          stroke_d  = 2'd0;
          state_d   = (letters[1:0] == CodeEnd) ? StFinish : StEmit;
        end
      end
      StEmit: begin
        if (rect_ready) begin
          if (!last_stroke) begin
            stroke_d = stroke_q + 2'd1;
          end else if (slot_q == 2'd3 || nxt_code == CodeEnd) begin
            state_d = StFinish;
          end else begin
            slot_d   = slot_nxt;
            stroke_d = 2'd0;
          end
        end
        // Abort wins over advancing; a coinciding transfer has still happened.
        if (abort_req) begin
          state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Stroke offsets relative to the slot origin.
  always_comb begin
    dx1 = 32'd0;
    dy1 = 32'd0;
    dx2 = S1;
    dy2 = S3;
    if (cur_code == CodeG) begin
      dy2 = S1;
    end else if (cur_code == CodeU) begin
      if (stroke_q == 2'd1) begin
        dx1 = S1;
        dy1 = S2;
        dx2 = S2;
      end else if (stroke_q == 2'd2) begin
        dx1 = S2;
        dx2 = S3;
      end
    end
  end

  assign ox = base_x_q + 32'(slot_q) * PitchW;

  always_comb begin
    rect_valid = (state_q == StEmit);
    busy       = (state_q != StIdle);
    done       = (state_q == StFinish);
    rect_x1    = 32'd0;
    rect_y1    = 32'd0;
    rect_x2    = 32'd0;
    rect_y2    = 32'd0;
    if (state_q == StEmit) begin
      rect_x1 = ox + dx1;
      rect_y1 = base_y_q + dy1;
      rect_x2 = ox + dx2;
      rect_y2 = base_y_q + dy2;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      base_x_q  <= 32'd0;
      base_y_q  <= 32'd0;
      letters_q <= 8'd0;
      slot_q    <= 2'd0;
      stroke_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      base_x_q  <= base_x_d;
      base_y_q  <= base_y_d;
      letters_q <= letters_d;
      slot_q    <= slot_d;
      stroke_q  <= stroke_d;
    end
  end

endmodule

// File: tb/tb_text_rect_sequencer.sv
// Self-checking bench for text_rect_sequencer: vector table, randomized words against a
// stroke-list model, and hand sequences for reset/abort corners.
module tb_text_rect_sequencer;

  localparam int unsigned PITCH  = 128;
  localparam int unsigned STROKE = 32;
  localparam logic [31:0] S      = 32'(STROKE);

  typedef struct {
    logic [31:0] x1;
    logic [31:0] y1;
    logic [31:0] x2;
    logic [31:0] y2;
  } rect_t;

  typedef struct {
    logic [7:0]  lt;
    logic [31:0] bx;
    logic [31:0] by;
    int          mode;
    int          n_rects;
    int          n_cycles;
    rect_t       last;
  } vec_t;

  logic        clock;
  logic        resetn;
  logic        abort;
  logic        start;
  logic [31:0] base_x;
  logic [31:0] base_y;
  logic [7:0]  letters;
  logic        rect_ready;
  logic        rect_valid;
  logic [31:0] rect_x1, rect_y1, rect_x2, rect_y2;
  logic        busy;
  logic        done;

  int    n_total;
  int    n_pass;
  rect_t exp_q[$];
  vec_t  tbl[7];

  text_rect_sequencer #(
    .PITCH (PITCH),
    .STROKE(STROKE)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
`ifdef TEXT_RECT_SEQUENCER_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .base_x    (base_x),
    .base_y    (base_y),
    .letters   (letters),
    .rect_ready(rect_ready),
    .rect_valid(rect_valid),
    .rect_x1   (rect_x1),
    .rect_y1   (rect_y1),
    .rect_x2   (rect_x2),
    .rect_y2   (rect_y2),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: list every stroke of the word from the glyph shapes.
  task automatic build_expected(input logic [7:0] lt, input logic [31:0] bx,
                                input logic [31:0] by);
    logic [1:0]  code;
    logic [31:0] ox;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      code = lt[2*k +: 2];
      if (code == 2'd0) break;
      ox = bx + 32'(k) * 32'(PITCH);
      case (code)
        2'd1: exp_q.push_back(rect_t'{ox, by, ox + S, by + 3 * S});
        2'd2: begin
          exp_q.push_back(rect_t'{ox, by, ox + S, by + 3 * S});
          exp_q.push_back(rect_t'{ox + S, by + 2 * S, ox + 2 * S, by + 3 * S});
          exp_q.push_back(rect_t'{ox + 2 * S, by, ox + 3 * S, by + 3 * S});
        end
        default: exp_q.push_back(rect_t'{ox, by, ox + S, by + S});
      endcase
    end
  endtask

  // Called and returns just after a falling edge with the DUT idle.
  // mode 0: ready held high, 1: random ready, 2: ready low for 5 cycles then high.
  task automatic run_word(input logic [7:0] lt, input logic [31:0] bx, input logic [31:0] by,
                          input int mode, output int n_got, output int n_cyc,
                          output rect_t last);
    rect_t cur;
    n_got = 0;
    n_cyc = 0;
    last  = rect_t'{32'd0, 32'd0, 32'd0, 32'd0};
    build_expected(lt, bx, by);
    start   = 1'b1;
    letters = lt;
    base_x  = bx;
    base_y  = by;
    @(negedge clock);
    while (exp_q.size() > 0 && n_cyc < 200) begin
      cur = rect_t'{rect_x1, rect_y1, rect_x2, rect_y2};
      check("valid", {31'd0, rect_valid}, 32'd1);
      check("busy", {31'd0, busy}, 32'd1);
      check("done_early", {31'd0, done}, 32'd0);
      check("x1", cur.x1, exp_q[0].x1);
      check("y1", cur.y1, exp_q[0].y1);
      check("x2", cur.x2, exp_q[0].x2);
      check("y2", cur.y2, exp_q[0].y2);
      case (mode)
        0:       rect_ready = 1'b1;
        1:       rect_ready = 1'($urandom_range(0, 1));
        default: rect_ready = (n_cyc >= 5);
      endcase
      start   = 1'($urandom_range(0, 1));
      letters = 8'($urandom);
      base_x  = $urandom;
      base_y  = $urandom;
      @(negedge clock);
      if (rect_ready) begin
        void'(exp_q.pop_front());
        last = cur;
        n_got++;
      end
      n_cyc++;
    end
    if (exp_q.size() > 0) begin
      check("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    check("done", {31'd0, done}, 32'd1);
    check("valid_fin", {31'd0, rect_valid}, 32'd0);
    check("busy_fin", {31'd0, busy}, 32'd1);
    rect_ready = 1'b0;
    start      = 1'($urandom_range(0, 1));
    @(negedge clock);
    start = 1'b0;
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("done_idle", {31'd0, done}, 32'd0);
    check("valid_idle", {31'd0, rect_valid}, 32'd0);
  endtask

  initial begin
    int    n_got, n_cyc;
    rect_t last;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n_got, n_cyc;
    rect_t last;
    n_total    = 0;
    n_pass     = 0;
    resetn     = 1'b0;
    abort      = 1'b0;
    start      = 1'b0;
    base_x     = 32'd0;
    base_y     = 32'd0;
    letters    = 8'd0;
    rect_ready = 1'b0;

    tbl[0] = '{8'b00_11_10_01, 32'd100, 32'd50, 0, 5, 5, rect_t'{32'd356, 32'd50, 32'd388, 32'd82}};
    tbl[1] = '{8'b00_00_00_00, 32'd77, 32'd88, 0, 0, 0, rect_t'{32'd0, 32'd0, 32'd0, 32'd0}};
    tbl[2] = '{8'b00_00_00_10, 32'd0, 32'd0, 2, 3, 8, rect_t'{32'd64, 32'd0, 32'd96, 32'd96}};
    tbl[3] = '{8'b00_00_00_01, 32'hFFFF_FFF0, 32'd7, 0, 1, 1,
               rect_t'{32'hFFFF_FFF0, 32'd7, 32'h0000_0010, 32'd103}};
    tbl[4] = '{8'hFF, 32'd10, 32'd20, 0, 4, 4, rect_t'{32'd394, 32'd20, 32'd426, 32'd52}};
    tbl[5] = '{8'b01_00_10_01, 32'd0, 32'd0, 0, 4, 4, rect_t'{32'd192, 32'd0, 32'd224, 32'd96}};
    tbl[6] = '{8'hAA, 32'd1000, 32'd2000, 1, 12, -1,
               rect_t'{32'd1448, 32'd2000, 32'd1480, 32'd2096}};

    #12;
    check("rst_valid", {31'd0, rect_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_x1", rect_x1, 32'd0);
    check("rst_y1", rect_y1, 32'd0);
    check("rst_x2", rect_x2, 32'd0);
    check("rst_y2", rect_y2, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_word(tbl[i].lt, tbl[i].bx, tbl[i].by, tbl[i].mode, n_got, n_cyc, last);
      check("tbl_n_rects", 32'(n_got), 32'(tbl[i].n_rects));
      if (tbl[i].n_cycles >= 0) check("tbl_n_cycles", 32'(n_cyc), 32'(tbl[i].n_cycles));
      if (tbl[i].n_rects > 0) begin
        check("tbl_last_x1", last.x1, tbl[i].last.x1);
        check("tbl_last_y1", last.y1, tbl[i].last.y1);
        check("tbl_last_x2", last.x2, tbl[i].last.x2);
        check("tbl_last_y2", last.y2, tbl[i].last.y2);
      end
    end

    for (int i = 0; i < 25; i++) begin
      run_word(8'($urandom), $urandom, $urandom, 1, n_got, n_cyc, last);
    end

    // Reset asserted while the second 'u' stroke is on the outputs.
    start      = 1'b1;
    letters    = 8'b00_00_00_10;
    base_x     = 32'd0;
    base_y     = 32'd0;
    rect_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("r39_s0_x1", rect_x1, 32'd0);
    @(negedge clock);
    check("r39_s1_x1", rect_x1, 32'd32);
    check("r39_s1_y1", rect_y1, 32'd64);
    #2 resetn = 1'b0;
    #1;
    check("r39_valid_async", {31'd0, rect_valid}, 32'd0);
    check("r39_busy_async", {31'd0, busy}, 32'd0);
    check("r39_x2_async", rect_x2, 32'd0);
    @(negedge clock);
    check("r39_no_done", {31'd0, done}, 32'd0);
    resetn = 1'b1;
    rect_ready = 1'b0;
    @(negedge clock);
    check("r39_idle_valid", {31'd0, rect_valid}, 32'd0);
    check("r39_idle_busy", {31'd0, busy}, 32'd0);
    run_word(8'b00_00_00_10, 32'd0, 32'd0, 0, n_got, n_cyc, last);
    check("r39_rerun_n", 32'(n_got), 32'd3);

`ifdef TEXT_RECT_SEQUENCER_ABORT_EN
    // Abort while the first stroke is stalled.
    start      = 1'b1;
    letters    = 8'b00_00_00_10;
    rect_ready = 1'b0;
    @(negedge clock);
    check("ab_s0_x2", rect_x2, 32'd32);
    @(negedge clock);
    check("ab_held_x2", rect_x2, 32'd32);
    check("ab_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("ab_done", {31'd0, done}, 32'd1);
    check("ab_valid", {31'd0, rect_valid}, 32'd0);
    @(negedge clock);
    start = 1'b0;
    check("ab_idle", {31'd0, busy}, 32'd0);
    check("ab_idle_valid", {31'd0, rect_valid}, 32'd0);
    // Abort coinciding with a transfer.
    start      = 1'b1;
    rect_ready = 1'b1;
    @(negedge clock);
    check("abx_valid", {31'd0, rect_valid}, 32'd1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    rect_ready = 1'b0;
    check("abx_done", {31'd0, done}, 32'd1);
    check("abx_valid_fin", {31'd0, rect_valid}, 32'd0);
    @(negedge clock);
    start = 1'b0;
    check("abx_idle", {31'd0, busy}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
